rgmii_rx_stim: RTL and testbench



---
 rtl/rgmii_rx_stim.sv | 214 +++++++++++++++++++++
 tb/tb_rgmii_rx_stim.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_stim.sv
// RGMII receive-side stimulus generator.
// Converts an AXI-stream byte source into a PHY-style RGMII RX stream (preamble, SFD,
// payload, inter-frame gap) as rise/fall pairs for ODDR primitives.
// Ports:
//   clk_125, reset_n         single 125 MHz clock, asynchronous active-low reset
//   speed_sel                10 = 1000, 01 = 100, 00 = 10 Mb/s, 11 = 1000
//   s_axis_*                 byte source; s_axis_tuser forces RX_ER on that byte
//   rgmii_rxd_rise/fall      nibble per half-cycle
//   rgmii_rxctl_rise/fall    RX_DV / RX_DV ^ RX_ER
//   rgmii_rxc_rise/fall      generated rxc level per half-cycle
//   busy                     FSM not idle
//   frame_count              completed frames (wraps)
//   underrun_count           DATA slots sent without a valid input byte (wraps)
module rgmii_rx_stim #(
   parameter int unsigned PREAMBLE_BYTES = 7,
   parameter int unsigned IFG_BYTES      = 12,
   parameter int unsigned DIV_100M       = 5,
   parameter int unsigned DIV_10M        = 50
) (
   input  logic        clk_125,
   input  logic        reset_n,
   input  logic [1:0]  speed_sel,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic        s_axis_trdy,
   output logic [3:0]  rgmii_rxd_rise,
   output logic [3:0]  rgmii_rxd_fall,
   output logic        rgmii_rxctl_rise,
   output logic        rgmii_rxctl_fall,
   output logic        rgmii_rxc_rise,
   output logic        rgmii_rxc_fall,
   output logic        busy,
   output logic [15:0] frame_count,
   output logic [15:0] underrun_count
);

   localparam int unsigned DIV_MAX = (DIV_10M > DIV_100M) ? DIV_10M : DIV_100M;
   localparam int unsigned CW      = $clog2(2 * DIV_MAX + 1);
   localparam int unsigned IDX_MAX = (PREAMBLE_BYTES > IFG_BYTES) ? PREAMBLE_BYTES : IFG_BYTES;
   localparam int unsigned IW      = $clog2(IDX_MAX + 1);

   typedef enum logic [2:0] {StIdle, StPreamble, StSfd, StData, StIfg} state_t;

   state_t        state_q, state_d;
   logic          sdr_q, sdr_d;
   logic [CW-1:0] div_q, div_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [7:0]    byte_q, byte_d;
   logic          err_q, err_d;
   logic          last_q, last_d;
   logic [15:0]   frames_d, underruns_d;

   logic          slot_end, start, accept, dv, er, second_half;
   logic [7:0]    wire_byte;
   logic [3:0]    nib;
   logic [CW-1:0] phase;
   logic [3:0]    rxd_rise_d, rxd_fall_d;
   logic          rxc_rise_d, rxc_fall_d, trdy_d;

   // Index of the final cycle in a byte slot: 0 at 1000, 2*DIV-1 in SDR modes.
   function automatic logic [CW-1:0] slot_m1(input logic sdr, input logic [CW-1:0] div);
      return sdr ? ((div << 1) - CW'(1)) : '0;
   endfunction

   assign slot_end = (cnt_q == slot_m1(sdr_q, div_q));

   always_comb begin
      state_d     = state_q;
      sdr_d       = sdr_q;
      div_d       = div_q;
      idx_d       = idx_q;
      byte_d      = byte_q;
      err_d       = err_q;
      last_d      = last_q;
      frames_d    = frame_count;
      underruns_d = underrun_count;
      // The slot counter free-runs so rxc keeps toggling in IDLE and IFG.
      cnt_d       = slot_end ? '0 : cnt_q + CW'(1);
      start       = 1'b0;
      accept      = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (s_axis_tvalid) start = 1'b1;
         end
         StPreamble: begin
            if (slot_end) begin
               if (idx_q == IW'(PREAMBLE_BYTES - 1)) state_d = StSfd;
               else                                  idx_d   = idx_q + IW'(1);
            end
         end
         StSfd: begin
            if (slot_end) accept = 1'b1;
         end
         StData: begin
            if (slot_end) begin
               if (last_q) begin
                  state_d  = StIfg;
                  idx_d    = '0;
                  frames_d = frame_count + 16'd1;
               end else begin
                  accept = 1'b1;
               end
            end
         end
         StIfg: begin
            if (slot_end) begin
               // A waiting frame starts straight after the gap, with no extra idle cycle.
               if (idx_q == IW'(IFG_BYTES - 1)) begin
                  if (s_axis_tvalid) start   = 1'b1;
                  else               state_d = StIdle;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (start) begin
         state_d = StPreamble;
         idx_d   = '0;
         cnt_d   = '0;
         unique case (speed_sel)
            2'b01:   begin sdr_d = 1'b1; div_d = CW'(DIV_100M); end
            2'b00:   begin sdr_d = 1'b1; div_d = CW'(DIV_10M);  end
            default: begin sdr_d = 1'b0; div_d = '0;            end
         endcase
      end

      if (accept) begin
         state_d = StData;
         byte_d  = s_axis_tvalid ? s_axis_tdata : 8'h00;
         err_d   = s_axis_tvalid ? s_axis_tuser : 1'b1;
         last_d  = s_axis_tvalid & s_axis_tlast;
         if (!s_axis_tvalid) underruns_d = underrun_count + 16'd1;
      end

      // Outputs are derived from the next state so they are registered with it.
      dv = (state_d == StPreamble) || (state_d == StSfd) || (state_d == StData);
      er = (state_d == StData) && err_d;
      unique case (state_d)
         StPreamble: wire_byte = 8'h55;
         StSfd:      wire_byte = 8'hD5;
         StData:     wire_byte = byte_d;
         default:    wire_byte = 8'h00;
      endcase

      second_half = (cnt_d >= div_d);
      phase       = second_half ? (cnt_d - div_d) : cnt_d;
      nib         = second_half ? wire_byte[7:4] : wire_byte[3:0];
      if (sdr_d) begin
         rxd_rise_d = nib;
         rxd_fall_d = nib;
         // rxc high for the first DIV of the 2*DIV half-cycles in each period.
         rxc_rise_d = ({phase, 1'b0} < {1'b0, div_d});
         rxc_fall_d = ({phase, 1'b1} < {1'b0, div_d});
      end else begin
         rxd_rise_d = wire_byte[3:0];
         rxd_fall_d = wire_byte[7:4];
         rxc_rise_d = 1'b1;
         rxc_fall_d = 1'b0;
      end

      trdy_d = ((state_d == StSfd) || ((state_d == StData) && !last_d)) &&
               (cnt_d == slot_m1(sdr_d, div_d));
   end

   always_ff @(posedge clk_125 or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= StIdle;
         sdr_q            <= 1'b0;
         div_q            <= '0;
         cnt_q            <= '0;
         idx_q            <= '0;
         byte_q           <= 8'h00;
         err_q            <= 1'b0;
         last_q           <= 1'b0;
         frame_count      <= 16'd0;
         underrun_count   <= 16'd0;
         s_axis_trdy      <= 1'b0;
         rgmii_rxd_rise   <= 4'h0;
         rgmii_rxd_fall   <= 4'h0;
         rgmii_rxctl_rise <= 1'b0;
         rgmii_rxctl_fall <= 1'b0;
         rgmii_rxc_rise   <= 1'b1;
         rgmii_rxc_fall   <= 1'b0;
         busy             <= 1'b0;
      end else begin
         state_q          <= state_d;
         sdr_q            <= sdr_d;
         div_q            <= div_d;
         cnt_q            <= cnt_d;
         idx_q            <= idx_d;
         byte_q           <= byte_d;
         err_q            <= err_d;
         last_q           <= last_d;
         frame_count      <= frames_d;
         underrun_count   <= underruns_d;
         s_axis_trdy      <= trdy_d;
         rgmii_rxd_rise   <= rxd_rise_d;
         rgmii_rxd_fall   <= rxd_fall_d;
         rgmii_rxctl_rise <= dv;
         rgmii_rxctl_fall <= dv ^ er;
         rgmii_rxc_rise   <= rxc_rise_d;
         rgmii_rxc_fall   <= rxc_fall_d;
         busy             <= (state_d != StIdle);
      end
   end

endmodule

// File: tb/tb_rgmii_rx_stim.sv
// Bench for rgmii_rx_stim: expected wire slots are queued per frame when stimulus is
// built and popped by a monitor on every DV cycle; counters and timing checked per test.
module tb_rgmii_rx_stim;

   typedef struct packed {
      logic       valid;
      logic [7:0] data;
      logic       user;
      logic       last;
   } item_t;

   logic        clk_125 = 1'b0;
   logic        reset_n;
   logic [1:0]  speed_sel;
   logic [7:0]  s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tuser;
   logic        s_axis_trdy;
   logic [3:0]  rgmii_rxd_rise;
   logic [3:0]  rgmii_rxd_fall;
   logic        rgmii_rxctl_rise;
   logic        rgmii_rxctl_fall;
   logic        rgmii_rxc_rise;
   logic        rgmii_rxc_fall;
   logic        busy;
   logic [15:0] frame_count;
   logic [15:0] underrun_count;

   rgmii_rx_stim dut (
      .clk_125          (clk_125),
      .reset_n          (reset_n),
      .speed_sel        (speed_sel),
      .s_axis_tdata     (s_axis_tdata),
      .s_axis_tvalid    (s_axis_tvalid),
      .s_axis_tlast     (s_axis_tlast),
      .s_axis_tuser     (s_axis_tuser),
      .s_axis_trdy      (s_axis_trdy),
      .rgmii_rxd_rise   (rgmii_rxd_rise),
      .rgmii_rxd_fall   (rgmii_rxd_fall),
      .rgmii_rxctl_rise (rgmii_rxctl_rise),
      .rgmii_rxctl_fall (rgmii_rxctl_fall),
      .rgmii_rxc_rise   (rgmii_rxc_rise),
      .rgmii_rxc_fall   (rgmii_rxc_fall),
      .busy             (busy),
      .frame_count      (frame_count),
      .underrun_count   (underrun_count)
   );

   always #4 clk_125 = ~clk_125;

   // Scoreboard entry: {rxd_rise, rxd_fall, rxctl_rise, rxctl_fall, rxc_rise, rxc_fall}
   logic [11:0] exp_q [$];
   logic [1:0]  rxc100 [5];
   int          n_tests;
   int          n_fail;
   int          exp_frames;
   int          exp_underruns;
   int          gap_run;
   int          gap_last;
   logic        dv_prev;
   bit          mon_en;

   function automatic item_t mk(input logic v, input logic [7:0] d, input logic u,
                                input logic l);
      item_t it;
      it.valid = v;
      it.data  = d;
      it.user  = u;
      it.last  = l;
      return it;
   endfunction

   function automatic void push_slot(input logic [7:0] d, input logic er, input logic sdr);
      logic [3:0] nib;
      if (!sdr) begin
         exp_q.push_back({d[3:0], d[7:4], 1'b1, ~er, 2'b10});
      end else begin
         for (int c = 0; c < 10; c++) begin
            nib = (c < 5) ? d[3:0] : d[7:4];
            exp_q.push_back({nib, nib, 1'b1, ~er, rxc100[c % 5]});
         end
      end
   endfunction

   function automatic void push_frame(input item_t items[$], input logic sdr);
      for (int i = 0; i < 7; i++) push_slot(8'h55, 1'b0, sdr);
      push_slot(8'hD5, 1'b0, sdr);
      foreach (items[i]) begin
         if (items[i].valid) begin
            push_slot(items[i].data, items[i].user, sdr);
         end else begin
            push_slot(8'h00, 1'b1, sdr);
            exp_underruns++;
         end
      end
      exp_frames++;
   endfunction

   task automatic monitor();
      logic [11:0] obs;
      logic [11:0] exp;
      forever begin
         @(negedge clk_125);
         if (mon_en && reset_n) begin
            obs = {rgmii_rxd_rise, rgmii_rxd_fall, rgmii_rxctl_rise, rgmii_rxctl_fall,
                   rgmii_rxc_rise, rgmii_rxc_fall};
            n_tests++;
            if (rgmii_rxctl_rise) begin
               if (!dv_prev) gap_last = gap_run;
               gap_run = 0;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL wire_unexpected: got %h, required no DV", obs);
               end else begin
                  exp = exp_q.pop_front();
                  if (obs !== exp) begin
                     n_fail++;
                     $display("FAIL wire_slot at %0t: got %h, required %h", $time, obs, exp);
                  end
               end
            end else begin
               gap_run++;
               if ({obs[11:4], obs[2]} !== 9'h000) begin
                  n_fail++;
                  $display("FAIL wire_idle at %0t: got %h, required rxd=0 rxctl=0", $time, obs);
               end
            end
            dv_prev = rgmii_rxctl_rise;
         end
      end
   endtask

   task automatic drive_items(input item_t items[$]);
      int n;
      foreach (items[i]) begin
         s_axis_tvalid = items[i].valid;
         s_axis_tdata  = items[i].data;
         s_axis_tuser  = items[i].user;
         s_axis_tlast  = items[i].last;
         n = 0;
         do begin
            @(negedge clk_125);
            n++;
         end while (!s_axis_trdy && n < 4000);
         n_tests++;
         if (!s_axis_trdy) begin
            n_fail++;
            $display("FAIL trdy_timeout: got no trdy in %0d cycles, required trdy", n);
            break;
         end
         @(posedge clk_125);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      do begin
         @(negedge clk_125);
         n++;
      end while ((busy || exp_q.size() != 0) && n < 5000);
      n_tests++;
      if (busy || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_idle_timeout: got busy=%0b pending=%0d, required idle", name, busy,
                  exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset_n       = 1'b0;
      speed_sel     = 2'b10;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      s_axis_tuser  = 1'b0;
      s_axis_tlast  = 1'b0;
      repeat (3) @(posedge clk_125);
      @(negedge clk_125);
      n_tests++;
      if ({rgmii_rxd_rise, rgmii_rxd_fall, rgmii_rxctl_rise, rgmii_rxctl_fall} !== 10'h0) begin
         n_fail++;
         $display("FAIL reset_wire: got %h, required 0", {rgmii_rxd_rise, rgmii_rxd_fall,
                  rgmii_rxctl_rise, rgmii_rxctl_fall});
      end
      n_tests++;
      if ({rgmii_rxc_rise, rgmii_rxc_fall} !== 2'b10) begin
         n_fail++;
         $display("FAIL reset_rxc: got %b, required 10", {rgmii_rxc_rise, rgmii_rxc_fall});
      end
      n_tests++;
      if ({s_axis_trdy, busy, frame_count, underrun_count} !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got trdy=%0b busy=%0b frames=%0d underruns=%0d, required 0",
                  s_axis_trdy, busy, frame_count, underrun_count);
      end
      @(posedge clk_125);
      #1 reset_n = 1'b1;
      repeat (3) @(negedge clk_125);
      n_tests++;
      if (busy !== 1'b0 || rgmii_rxctl_rise !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_after_reset: got busy=%0b dv=%0b, required 0 0", busy,
                  rgmii_rxctl_rise);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_reset_mid_frame();
      item_t fr[$];
      mon_en = 1'b0;
      @(posedge clk_125);
      #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h77;
      s_axis_tlast  = 1'b0;
      repeat (12) @(negedge clk_125);
      n_tests++;
      if (rgmii_rxctl_rise !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL midframe_active: got dv=%0b busy=%0b, required 1 1", rgmii_rxctl_rise,
                  busy);
      end
      reset_n = 1'b0;
      #1;
      n_tests++;
      if ({rgmii_rxd_rise, rgmii_rxd_fall, rgmii_rxctl_rise, rgmii_rxctl_fall, rgmii_rxc_rise,
           rgmii_rxc_fall, s_axis_trdy, busy} !== 14'b00000000_00_10_00) begin
         n_fail++;
         $display("FAIL midframe_reset_outputs: got %b, required all reset values",
                  {rgmii_rxd_rise, rgmii_rxd_fall, rgmii_rxctl_rise, rgmii_rxctl_fall,
                   rgmii_rxc_rise, rgmii_rxc_fall, s_axis_trdy, busy});
      end
      n_tests++;
      if (frame_count !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL midframe_frame_count: got %0d, required %0d", frame_count, exp_frames);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 8'h00;
      repeat (2) @(posedge clk_125);
      #1 reset_n = 1'b1;
      exp_q.delete();
      exp_underruns = 0;
      dv_prev = 1'b0;
      mon_en = 1'b1;
      fr = '{mk(1, 8'h5A, 0, 0), mk(1, 8'hC3, 0, 1)};
      push_frame(fr, 1'b0);
      drive_items(fr);
      wait_idle("after_reset");
      n_tests++;
      if (frame_count !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL after_reset_frame_count: got %0d, required %0d", frame_count, exp_frames);
      end
   endtask

   task automatic test_latency();
      item_t fr[$];
      fr = '{mk(1, 8'h3C, 0, 1)};
      push_frame(fr, 1'b0);
      @(posedge clk_125);
      #1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 8'h3C;
      s_axis_tlast  = 1'b1;
      for (int k = 0; k <= 9; k++) begin
         @(negedge clk_125);
         if (k == 0 || k == 1) begin
            n_tests++;
            if (rgmii_rxctl_rise !== (k == 1)) begin
               n_fail++;
               $display("FAIL latency_dv_cycle%0d: got %0b, required %0b", k, rgmii_rxctl_rise,
                        k == 1);
            end
         end
         if (k == 7 || k == 8 || k == 9) begin
            n_tests++;
            if (s_axis_trdy !== (k == 8)) begin
               n_fail++;
               $display("FAIL latency_trdy_cycle%0d: got %0b, required %0b", k, s_axis_trdy,
                        k == 8);
            end
         end
         if (k == 8) begin
            n_tests++;
            if ({rgmii_rxd_rise, rgmii_rxd_fall} !== 8'h5D) begin
               n_fail++;
               $display("FAIL latency_sfd: got %h, required 5d",
                        {rgmii_rxd_rise, rgmii_rxd_fall});
            end
            @(posedge clk_125);
            #1;
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
         end
         if (k == 9) begin
            n_tests++;
            if ({rgmii_rxd_rise, rgmii_rxd_fall} !== 8'hC3) begin
               n_fail++;
               $display("FAIL latency_data: got %h, required c3",
                        {rgmii_rxd_rise, rgmii_rxd_fall});
            end
         end
      end
      wait_idle("latency");
      n_tests++;
      if (frame_count !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL latency_frame_count: got %0d, required %0d", frame_count, exp_frames);
      end
   endtask

   task automatic test_ddr_frame();
      item_t fr[$];
      fr = '{mk(1, 8'hDE, 0, 0), mk(1, 8'hAD, 0, 0), mk(1, 8'hBE, 0, 0), mk(1, 8'hEF, 0, 1)};
      push_frame(fr, 1'b0);
      drive_items(fr);
      wait_idle("ddr");
      n_tests++;
      if (frame_count !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL ddr_frame_count: got %0d, required %0d", frame_count, exp_frames);
      end
   endtask

   task automatic test_sdr_100();
      item_t fr[$];
      speed_sel = 2'b01;
      fr = '{mk(1, 8'hA3, 0, 1)};
      push_frame(fr, 1'b1);
      drive_items(fr);
      speed_sel = 2'b10;
      wait_idle("sdr100");
      n_tests++;
      if (frame_count !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL sdr100_frame_count: got %0d, required %0d", frame_count, exp_frames);
      end
   endtask

   task automatic test_tuser();
      item_t fr[$];
      // Error on the second byte, and on the tlast byte which must still close the frame.
      fr = '{mk(1, 8'h11, 0, 0), mk(1, 8'h22, 1, 0), mk(1, 8'h44, 0, 0), mk(1, 8'h33, 1, 1)};
      push_frame(fr, 1'b0);
      drive_items(fr);
      wait_idle("tuser");
      n_tests++;
      if (frame_count !== 16'(exp_frames) || underrun_count !== 16'(exp_underruns)) begin
         n_fail++;
         $display("FAIL tuser_counts: got frames=%0d underruns=%0d, required %0d %0d",
                  frame_count, underrun_count, exp_frames, exp_underruns);
      end
   endtask

   task automatic test_underrun();
      item_t fr[$];
      fr = '{mk(1, 8'h10, 0, 0), mk(1, 8'h01, 0, 0), mk(0, 8'h00, 0, 0), mk(0, 8'h00, 0, 0),
             mk(1, 8'h02, 0, 0), mk(1, 8'h03, 0, 1)};
      push_frame(fr, 1'b0);
      drive_items(fr);
      wait_idle("underrun");
      n_tests++;
      if (underrun_count !== 16'd2 || underrun_count !== 16'(exp_underruns)) begin
         n_fail++;
         $display("FAIL underrun_count: got %0d, required %0d", underrun_count, exp_underruns);
      end
      n_tests++;
      if (frame_count !== 16'(exp_frames)) begin
         n_fail++;
         $display("FAIL underrun_frame_count: got %0d, required %0d", frame_count, exp_frames);
      end
   endtask

   task automatic test_back_to_back();
      item_t fa[$];
      item_t fb[$];
      int    frames_before;
      frames_before = exp_frames;
      fa = '{mk(1, 8'hA1, 0, 0), mk(1, 8'hA2, 0, 1)};
      fb = '{mk(1, 8'hB1, 0, 0), mk(1, 8'hB2, 0, 0), mk(1, 8'hB3, 0, 1)};
      push_frame(fa, 1'b0);
      push_frame(fb, 1'b0);
      drive_items(fa);
      drive_items(fb);
      wait_idle("b2b");
      n_tests++;
      if (gap_last !== 12) begin
         n_fail++;
         $display("FAIL b2b_gap: got %0d DV=0 cycles, required 12", gap_last);
      end
      n_tests++;
      if (frame_count !== 16'(frames_before + 2)) begin
         n_fail++;
         $display("FAIL b2b_frame_count: got %0d, required %0d", frame_count, frames_before + 2);
      end
   endtask

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      exp_frames    = 0;
      exp_underruns = 0;
      gap_run       = 0;
      gap_last      = 0;
      dv_prev       = 1'b0;
      mon_en        = 1'b0;
      rxc100[0]     = 2'b11;
      rxc100[1]     = 2'b11;
      rxc100[2]     = 2'b10;
      rxc100[3]     = 2'b00;
      rxc100[4]     = 2'b00;
      fork
         monitor();
      join_none
      test_reset();
      test_reset_mid_frame();
      test_latency();
      test_ddr_frame();
      test_sdr_100();
      test_tuser();
      test_underrun();
      test_back_to_back();
      repeat (4) @(negedge clk_125);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
